cp0_exc_ctrl: RTL and testbench

Exception sequencer for the CP0 register file. Samples exception flags from the pipeline's commit point, picks one by fixed priority, sequences writes to BadVAddr, EPC, Cause and Status.EXL, flushes the pipeline, and redirects fetch to the handler. Also sequences ERET: clears EXL and redirects to EPC. Sits between the commit stage and the CP0 registers; drives their write enables and data directly.

---
 rtl/cp0_pkg.sv | 22 ++
 rtl/cp0_exc_prio.sv | 52 +++++
 rtl/cp0_exc_ctrl.sv | 153 +++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception sequencer: ExcCodes, handler vector and FSM states.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WRITE,
    ST_REDIRECT,
    ST_ERET
  } state_t;

endpackage

// File: rtl/cp0_exc_prio.sv
// Fixed-priority exception selector: picks one ExcCode and where its BadVAddr comes from.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic       if_adel,
  input  logic       ex_ri,
  input  logic       ex_ov,
  input  logic       ex_sys,
  input  logic       ex_bp,
  input  logic       mem_adel,
  input  logic       mem_ades,
  input  logic       int_pending,
  input  logic       status_exl,
  output logic       take,
  output logic [4:0] exccode,
  output logic       use_badvaddr,
  output logic       badvaddr_sel
);

  // badvaddr_sel: 0 selects the committing PC, 1 selects the data address.
  always_comb begin
    take         = 1'b1;
    exccode      = EXC_INT;
    use_badvaddr = 1'b0;
    badvaddr_sel = 1'b0;
    if (int_pending && !status_exl) begin
      exccode = EXC_INT;
    end else if (if_adel) begin
      exccode      = EXC_ADEL;
      use_badvaddr = 1'b1;
    end else if (ex_ri) begin
      exccode = EXC_RI;
    end else if (ex_ov) begin
      exccode = EXC_OV;
    end else if (ex_sys) begin
      exccode = EXC_SYS;
    end else if (ex_bp) begin
      exccode = EXC_BP;
    end else if (mem_adel) begin
      exccode      = EXC_ADEL;
      use_badvaddr = 1'b1;
      badvaddr_sel = 1'b1;
    end else if (mem_ades) begin
      exccode      = EXC_ADES;
      use_badvaddr = 1'b1;
      badvaddr_sel = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer: latches a committed exception, writes CP0 state, flushes and redirects fetch.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        if_adel,
  input  logic        ex_ri,
  input  logic        ex_ov,
  input  logic        ex_sys,
  input  logic        ex_bp,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic [31:0] mem_addr,
  input  logic        int_pending,
  input  logic        status_exl,
  input  logic        eret,
  input  logic [31:0] epc_value,
  output logic        busy,
  output logic        flush,
  output logic        badvaddr_write,
  output logic [31:0] badvaddr_addr,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic        cause_write,
  output logic [4:0]  cause_exccode,
  output logic        cause_bd,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  state_t      r_state;
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic        r_bd;
  logic        r_exl;
  logic        r_use_bva;
  logic [31:0] r_bva;

  logic        w_take;
  logic [4:0]  w_code;
  logic        w_use_bva;
  logic        w_bva_sel;
  logic        w_accept;

  cp0_exc_prio u_prio (
    .if_adel      (if_adel),
    .ex_ri        (ex_ri),
    .ex_ov        (ex_ov),
    .ex_sys       (ex_sys),
    .ex_bp        (ex_bp),
    .mem_adel     (mem_adel),
    .mem_ades     (mem_ades),
    .int_pending  (int_pending),
    .status_exl   (status_exl),
    .take         (w_take),
    .exccode      (w_code),
    .use_badvaddr (w_use_bva),
    .badvaddr_sel (w_bva_sel)
  );

  assign w_accept = (r_state == ST_IDLE) && exc_valid && w_take;

  // Exception context is only consumed while the FSM is busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_code    <= w_code;
      r_pc      <= exc_pc;
      r_bd      <= exc_bd;
      r_exl     <= status_exl;
      r_use_bva <= w_use_bva;
      r_bva     <= w_bva_sel ? mem_addr : exc_pc;
    end
  end

  // Outputs are registered alongside the next state, so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      busy           <= 1'b0;
      flush          <= 1'b0;
      badvaddr_write <= 1'b0;
      badvaddr_addr  <= '0;
      epc_write      <= 1'b0;
      epc_data       <= '0;
      cause_write    <= 1'b0;
      cause_exccode  <= '0;
      cause_bd       <= 1'b0;
      exl_set        <= 1'b0;
      exl_clr        <= 1'b0;
      pc_redirect    <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      busy           <= 1'b0;
      flush          <= 1'b0;
      badvaddr_write <= 1'b0;
      badvaddr_addr  <= '0;
      epc_write      <= 1'b0;
      epc_data       <= '0;
      cause_write    <= 1'b0;
      cause_exccode  <= '0;
      cause_bd       <= 1'b0;
      exl_set        <= 1'b0;
      exl_clr        <= 1'b0;
      pc_redirect    <= 1'b0;
      redirect_pc    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_CAPTURE;
            busy    <= 1'b1;
          end else if (exc_valid && eret) begin
            r_state     <= ST_ERET;
            busy        <= 1'b1;
            flush       <= 1'b1;
            exl_clr     <= 1'b1;
            pc_redirect <= 1'b1;
            redirect_pc <= epc_value;
          end
        end
        ST_CAPTURE: begin
          r_state        <= ST_WRITE;
          busy           <= 1'b1;
          flush          <= 1'b1;
          cause_write    <= 1'b1;
          cause_exccode  <= r_code;
          exl_set        <= 1'b1;
          badvaddr_write <= r_use_bva;
          badvaddr_addr  <= r_use_bva ? r_bva : 32'd0;
          // A nested exception (EXL already set) must preserve the original EPC and BD.
          epc_write      <= !r_exl;
          epc_data       <= r_exl ? 32'd0 : (r_bd ? r_pc - 32'd4 : r_pc);
          cause_bd       <= r_bd && !r_exl;
        end
        ST_WRITE: begin
          r_state     <= ST_REDIRECT;
          busy        <= 1'b1;
          pc_redirect <= 1'b1;
          redirect_pc <= EXC_VECTOR;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed vector table, reset corner case and randomized model check.
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  // f bits: [7]=int_pending [6]=if_adel [5]=ex_ri [4]=ex_ov [3]=ex_sys [2]=ex_bp [1]=mem_adel [0]=mem_ades
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [7:0]  f;
    logic [31:0] maddr;
    logic        exl;
    logic        eret;
    logic [31:0] epcv;
  } stim_t;

  typedef struct packed {
    logic        busy;
    logic        flush;
    logic        bvw;
    logic [31:0] bva;
    logic        epcw;
    logic [31:0] epcd;
    logic        cw;
    logic [4:0]  code;
    logic        bd;
    logic        set;
    logic        clr;
    logic        redir;
    logic [31:0] rpc;
  } out_t;

  typedef struct {
    stim_t s;
    int    kind;
    out_t  w;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid, exc_bd, if_adel, ex_ri, ex_ov, ex_sys, ex_bp;
  logic        mem_adel, mem_ades, int_pending, status_exl, eret;
  logic [31:0] exc_pc, mem_addr, epc_value;
  logic        busy, flush, badvaddr_write, epc_write, cause_write, cause_bd;
  logic        exl_set, exl_clr, pc_redirect;
  logic [31:0] badvaddr_addr, epc_data, redirect_pc;
  logic [4:0]  cause_exccode;
  out_t        act;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .if_adel(if_adel), .ex_ri(ex_ri), .ex_ov(ex_ov), .ex_sys(ex_sys), .ex_bp(ex_bp),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_addr(mem_addr),
    .int_pending(int_pending), .status_exl(status_exl), .eret(eret), .epc_value(epc_value),
    .busy(busy), .flush(flush), .badvaddr_write(badvaddr_write), .badvaddr_addr(badvaddr_addr),
    .epc_write(epc_write), .epc_data(epc_data), .cause_write(cause_write),
    .cause_exccode(cause_exccode), .cause_bd(cause_bd), .exl_set(exl_set), .exl_clr(exl_clr),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc)
  );

  assign act = {busy, flush, badvaddr_write, badvaddr_addr, epc_write, epc_data, cause_write,
                cause_exccode, cause_bd, exl_set, exl_clr, pc_redirect, redirect_pc};

  function automatic stim_t st(logic v, logic [31:0] pc, logic bd, logic [7:0] f,
                               logic [31:0] ma, logic exl, logic er, logic [31:0] ep);
    stim_t s;
    s.valid = v; s.pc = pc; s.bd = bd; s.f = f; s.maddr = ma;
    s.exl = exl; s.eret = er; s.epcv = ep;
    return s;
  endfunction

  function automatic out_t xw(logic [4:0] code, logic bvw, logic [31:0] bva,
                              logic epcw, logic [31:0] epcd, logic bd);
    out_t o = '0;
    o.busy = 1'b1; o.flush = 1'b1; o.cw = 1'b1; o.set = 1'b1;
    o.code = code; o.bvw = bvw; o.bva = bva; o.epcw = epcw; o.epcd = epcd; o.bd = bd;
    return o;
  endfunction

  // Reference: scan sources in priority order, derive the expected CP0 write cycle.
  function automatic void model(input stim_t s, output int kind, output out_t w);
    int          codes[8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    logic [7:0]  f;
    logic [31:0] epc;
    int          hit;
    kind = 0;
    w    = '0;
    hit  = -1;
    f    = s.f;
    f[7] = s.f[7] & ~s.exl;
    for (int i = 0; i < 8; i++)
      if (hit < 0 && f[7-i]) hit = i;
    if (!s.valid) return;
    if (hit >= 0) begin
      kind = 1;
      epc  = s.bd ? s.pc - 32'd4 : s.pc;
      w = xw(5'(codes[hit]), 1'b0, 32'd0, !s.exl, s.exl ? 32'd0 : epc, s.bd & ~s.exl);
      if (hit == 1) begin
        w.bvw = 1'b1; w.bva = s.pc;
      end else if (hit >= 6) begin
        w.bvw = 1'b1; w.bva = s.maddr;
      end
    end else if (s.eret) begin
      kind = 2;
    end
  endfunction

  task automatic apply(input stim_t s);
    exc_valid = s.valid; exc_pc = s.pc; exc_bd = s.bd;
    {int_pending, if_adel, ex_ri, ex_ov, ex_sys, ex_bp, mem_adel, mem_ades} = s.f;
    mem_addr = s.maddr; status_exl = s.exl; eret = s.eret; epc_value = s.epcv;
  endtask

  task automatic check(input string nm, input out_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives the request, then checks every cycle until back in IDLE.
  task automatic run_seq(input string nm, input stim_t s, input int kind, input out_t w);
    out_t o;
    apply(s);
    @(posedge clk);
    @(negedge clk);
    apply('0);
    if (kind == 1) begin
      o = '0; o.busy = 1'b1;
      check({nm, "/capture"}, o);
      @(negedge clk);
      check({nm, "/write"}, w);
      @(negedge clk);
      o = '0; o.busy = 1'b1; o.redir = 1'b1; o.rpc = 32'hBFC00380;
      check({nm, "/redirect"}, o);
      @(negedge clk);
      check({nm, "/idle"}, '0);
    end else if (kind == 2) begin
      o = '0; o.busy = 1'b1; o.flush = 1'b1; o.clr = 1'b1; o.redir = 1'b1; o.rpc = s.epcv;
      check({nm, "/eret"}, o);
      @(negedge clk);
      check({nm, "/idle"}, '0);
    end else begin
      check({nm, "/ignored"}, '0);
    end
  endtask

  vec_t  tv[11];
  stim_t rs;
  int    rk;
  out_t  rw;

  initial begin
    tv[0]  = '{st(1, 32'hBFC00100, 0, 8'b00000010, 32'h00000403, 0, 0, 0), 1,
               xw(5'd4, 1, 32'h00000403, 1, 32'hBFC00100, 0)};
    tv[1]  = '{st(1, 32'hBFC00202, 1, 8'b01000000, 32'h0, 0, 0, 0), 1,
               xw(5'd4, 1, 32'hBFC00202, 1, 32'hBFC001FE, 1)};
    tv[2]  = '{st(1, 32'h80000020, 0, 8'b10010001, 32'h12345678, 0, 0, 0), 1,
               xw(5'd0, 0, 32'h0, 1, 32'h80000020, 0)};
    tv[3]  = '{st(1, 32'h80000020, 1, 8'b10010001, 32'h12345678, 1, 0, 0), 1,
               xw(5'd12, 0, 32'h0, 0, 32'h0, 0)};
    tv[4]  = '{st(1, 32'h80001000, 0, 8'b00001000, 32'h0, 0, 0, 0), 1,
               xw(5'd8, 0, 32'h0, 1, 32'h80001000, 0)};
    tv[5]  = '{st(1, 32'h80001004, 0, 8'b00000000, 32'h0, 1, 1, 32'hBFC00010), 2, '0};
    tv[6]  = '{st(1, 32'h80002000, 0, 8'b00000100, 32'h0, 0, 1, 32'hDEAD0000), 1,
               xw(5'd9, 0, 32'h0, 1, 32'h80002000, 0)};
    tv[7]  = '{st(1, 32'h00000000, 1, 8'b00100000, 32'h0, 0, 0, 0), 1,
               xw(5'd10, 0, 32'h0, 1, 32'hFFFFFFFC, 1)};
    tv[8]  = '{st(1, 32'h80003000, 0, 8'b10000000, 32'h0, 1, 0, 0), 0, '0};
    tv[9]  = '{st(0, 32'h80003000, 0, 8'b00010000, 32'h0, 0, 1, 32'h11111111), 0, '0};
    tv[10] = '{st(1, 32'h80004000, 0, 8'b00000001, 32'h00000ABE, 0, 0, 0), 1,
               xw(5'd5, 1, 32'h00000ABE, 1, 32'h80004000, 0)};

    reset = 1'b1;
    apply('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", '0);

    for (int i = 0; i < 11; i++)
      run_seq($sformatf("vec%0d", i), tv[i].s, tv[i].kind, tv[i].w);

    // Reset sampled while in CAPTURE: the would-be WRITE cycle must show nothing.
    apply(st(1, 32'h80005000, 0, 8'b00000010, 32'h00000777, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    apply('0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_seq", '0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_seq_after", '0);
    run_seq("ades_after_reset", st(1, 32'h80006000, 0, 8'b00000001, 32'h00000102, 0, 0, 0), 1,
            xw(5'd5, 1, 32'h00000102, 1, 32'h80006000, 0));

    for (int n = 0; n < 60; n++) begin
      rs.valid = ($urandom_range(3) != 0);
      rs.pc    = $urandom;
      rs.bd    = 1'($urandom_range(1));
      for (int k = 0; k < 8; k++) rs.f[k] = ($urandom_range(5) == 0);
      rs.maddr = $urandom;
      rs.exl   = 1'($urandom_range(1));
      rs.eret  = ($urandom_range(2) == 0);
      rs.epcv  = $urandom;
      model(rs, rk, rw);
      run_seq($sformatf("rand%0d", n), rs, rk, rw);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
